// File: rtl/pll_seq_pkg.sv
// Shared types and widths for the PLL lock sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    RST_PLL   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } pll_state_t;

  localparam int LOSS_CNT_W = 8;
  localparam int RETRY_W    = 4;

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchronizer bringing the asynchronous PLL LOCK into the reference clock domain.
module pll_lock_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_sequencer.sv
// Power-up / relock sequencer for the board PLL: reset pulse, lock qualification,
// system reset release, lock-loss monitoring with bounded retries and a latched fault.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned RST_PULSE_CYC    = 16,
  parameter int unsigned LOCK_STABLE_CYC  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYC = 27000,
  parameter int unsigned MAX_RETRY        = 4,
  parameter int unsigned CNT_W            = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pll_lock_i,
  input  logic                  relock_req_i,
  output logic                  pll_reset_o,
  output logic                  sys_rst_n_o,
  output logic                  pll_ready_o,
  output logic                  fault_o,
  output logic [RETRY_W-1:0]    retry_cnt_o,
  output logic [LOSS_CNT_W-1:0] lock_loss_cnt_o,
  output pll_state_t            state_o
);

  localparam logic [CNT_W-1:0]   PULSE_LAST  = CNT_W'(RST_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0]   TO_LAST     = CNT_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRY);

  pll_state_t            state, state_next;
  logic                  lock_s;
  logic [CNT_W-1:0]      timer, timer_next;
  logic [CNT_W-1:0]      stable_cnt, stable_next;
  logic [RETRY_W-1:0]    retry_next;
  logic [LOSS_CNT_W-1:0] loss_next;

  pll_lock_sync u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_lock_i),
    .q     (lock_s)
  );

  assign state_o = state;

  // relock_req_i is a one-cycle strobe with no ready: it is acted on in the cycle it is
  // high (except during the reset pulse, where it is dropped) and never held pending.
  always_comb begin
    state_next  = state;
    timer_next  = timer + CNT_W'(1);
    stable_next = stable_cnt;
    retry_next  = retry_cnt_o;
    loss_next   = lock_loss_cnt_o;
    case (state)
      RST_PLL: begin
        if (timer == PULSE_LAST) begin
          state_next = WAIT_LOCK;
          timer_next = '0;
        end
      end
      WAIT_LOCK, STABLE: begin
        if (relock_req_i) begin
          state_next = RST_PLL;
          timer_next = '0;
        end else if (timer == TO_LAST) begin
          timer_next = '0;
          if (retry_cnt_o == RETRY_MAX) begin
            state_next = FAULT;
          end else begin
            state_next = RST_PLL;
            retry_next = retry_cnt_o + RETRY_W'(1);
          end
        end else if (state == WAIT_LOCK) begin
          if (lock_s) begin
            state_next  = STABLE;
            stable_next = '0;
          end
        end else if (!lock_s) begin
          // A glitch restarts qualification but not the attempt's timeout.
          state_next  = WAIT_LOCK;
          stable_next = '0;
        end else if (stable_cnt == STABLE_LAST) begin
          state_next = RUN;
          timer_next = '0;
          retry_next = '0;
        end else begin
          stable_next = stable_cnt + CNT_W'(1);
        end
      end
      RUN: begin
        timer_next = '0;
        if (!lock_s) begin
          state_next = RST_PLL;
          if (lock_loss_cnt_o != '1) loss_next = lock_loss_cnt_o + LOSS_CNT_W'(1);
        end else if (relock_req_i) begin
          state_next = RST_PLL;
        end
      end
      FAULT: begin
        timer_next = '0;
        if (relock_req_i) begin
          state_next = RST_PLL;
          retry_next = '0;
        end
      end
      default: begin
        state_next = RST_PLL;
        timer_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= RST_PLL;
      timer           <= '0;
      stable_cnt      <= '0;
      retry_cnt_o     <= '0;
      lock_loss_cnt_o <= '0;
      pll_reset_o     <= 1'b1;
      sys_rst_n_o     <= 1'b0;
      pll_ready_o     <= 1'b0;
      fault_o         <= 1'b0;
    end else begin
      state           <= state_next;
      timer           <= timer_next;
      stable_cnt      <= stable_next;
      retry_cnt_o     <= retry_next;
      lock_loss_cnt_o <= loss_next;
      // Outputs follow the next state so they switch on the same edge as the FSM.
      pll_reset_o     <= (state_next == RST_PLL);
      sys_rst_n_o     <= (state_next == RUN);
      pll_ready_o     <= (state_next == RUN);
      fault_o         <= (state_next == FAULT);
    end
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: directed scenarios plus random lock waveforms, all
// outputs compared every cycle against a phase/age reference model.
module tb_pll_lock_sequencer;
  import pll_seq_pkg::*;

  localparam int PULSE   = 4;
  localparam int STABLE_N = 8;
  localparam int TIMEOUT = 32;
  localparam int MAXR    = 2;
  localparam logic [15:0] RESET_VEC = 16'h8000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       pll_lock_i = 1'b0;
  logic       relock_req_i = 1'b0;
  logic       pll_reset_o, sys_rst_n_o, pll_ready_o, fault_o;
  logic [3:0] retry_cnt_o;
  logic [7:0] lock_loss_cnt_o;
  pll_state_t state_o;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [15:0] exp_q[$];
  logic pre_reset;

  // reference model: phase name, edges spent in the phase, run of lock_s highs
  string m_phase;
  int    m_age, m_hi, m_retry, m_loss;
  logic  m_s1, m_s2;

  pll_lock_sequencer #(
    .RST_PULSE_CYC(PULSE), .LOCK_STABLE_CYC(STABLE_N), .LOCK_TIMEOUT_CYC(TIMEOUT),
    .MAX_RETRY(MAXR), .CNT_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pll_lock_i(pll_lock_i), .relock_req_i(relock_req_i),
    .pll_reset_o(pll_reset_o), .sys_rst_n_o(sys_rst_n_o), .pll_ready_o(pll_ready_o),
    .fault_o(fault_o), .retry_cnt_o(retry_cnt_o), .lock_loss_cnt_o(lock_loss_cnt_o),
    .state_o(state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [15:0] obs_vec();
    return {pll_reset_o, sys_rst_n_o, pll_ready_o, fault_o, retry_cnt_o, lock_loss_cnt_o};
  endfunction

  function automatic logic [15:0] model_vec();
    logic p, r, f;
    p = (m_phase == "pulse");
    r = (m_phase == "run");
    f = (m_phase == "fault");
    return {p, r, r, f, 4'(m_retry), 8'(m_loss)};
  endfunction

  task automatic model_reset();
    m_phase = "pulse"; m_age = 0; m_hi = 0; m_retry = 0; m_loss = 0;
    m_s1 = 1'b0; m_s2 = 1'b0;
  endtask

  task automatic go_pulse();
    m_phase = "pulse";
    m_age = 0;
  endtask

  task automatic model_step(input logic lk, input logic rq);
    logic ls;
    ls = m_s2; m_s2 = m_s1; m_s1 = lk;
    if (m_phase == "pulse") begin
      m_age++;
      if (m_age == PULSE) begin m_phase = "wait"; m_age = 0; m_hi = 0; end
    end else if (m_phase == "wait") begin
      if (rq) go_pulse();
      else begin
        m_age++;
        if (m_age == TIMEOUT) begin
          if (m_retry == MAXR) m_phase = "fault";
          else begin m_retry++; go_pulse(); end
        end else if (ls) begin
          m_hi++;
          if (m_hi == STABLE_N + 1) begin m_phase = "run"; m_retry = 0; end
        end else m_hi = 0;
      end
    end else if (m_phase == "run") begin
      if (!ls) begin
        if (m_loss < 255) m_loss++;
        go_pulse();
      end else if (rq) go_pulse();
    end else if (m_phase == "fault") begin
      if (rq) begin m_retry = 0; go_pulse(); end
    end
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // driver
  task automatic step(input logic lk, input logic rq);
    @(negedge clk);
    pre_reset = pll_reset_o;
    pll_lock_i = lk;
    relock_req_i = rq;
    model_step(lk, rq);
    exp_q.push_back(model_vec());
    @(posedge clk);
  endtask

  task automatic do_reset();
    #3;
    rst_n = 1'b0;
    pll_lock_i = 1'b0;
    relock_req_i = 1'b0;
    #1;
    check("reset_vec", obs_vec(), RESET_VEC);
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic run_until(input string ph, input logic lk, input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      step(lk, 1'b0);
      if (m_phase == ph) return;
    end
    total++; bad++;
    $display("FAIL run_until_%s got=%s want=%s", ph, m_phase, ph);
  endtask

  task automatic count_pulse(input string name, input int n_steps, input int want);
    int hi;
    hi = 0;
    for (int i = 0; i < n_steps; i++) begin
      step(1'b0, 1'b0);
      if (pre_reset) hi++;
    end
    check(name, 16'(hi), 16'(want));
  endtask

  // scoreboard monitor
  always @(posedge clk) begin
    logic [15:0] e;
    #1;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs_vec() !== e) begin
        bad++;
        $display("FAIL scoreboard cyc=%0d got=%h want=%h", cyc, obs_vec(), e);
      end
    end
  end

  initial begin
    logic cur;
    int   seg;
    model_reset();

    // 1: power-up with lock arriving 10 cycles after reset release
    do_reset();
    count_pulse("t1_pulse_width", 10, PULSE);
    for (int i = 0; i < 30; i++) step(1'b1, 1'b0);
    #1;
    check("t1_ready", {14'd0, sys_rst_n_o, pll_ready_o}, 16'h3);

    // 2: lock never arrives -> three pulses then latched fault
    do_reset();
    count_pulse("t2_pulse_cycles", 130, 3 * PULSE);
    #1;
    check("t2_fault", 16'(fault_o), 16'd1);
    check("t2_retry", 16'(retry_cnt_o), 16'(MAXR));
    check("t2_outs_low", {14'd0, pll_reset_o, sys_rst_n_o}, 16'd0);

    // 5a: relock out of fault
    step(1'b0, 1'b1);
    #1;
    check("t5_fault_clr", {fault_o, 7'd0, retry_cnt_o, 3'd0, pll_reset_o}, 16'h0001);
    run_until("run", 1'b1, 60);

    // 3a: glitch at stable count 5, early enough to still reach RUN
    step(1'b1, 1'b1);
    run_until("wait", 1'b1, 20);
    for (int i = 0; i < 30 && m_hi < 6; i++) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    run_until("run", 1'b1, 40);
    #1;
    check("t3_run_after_glitch", 16'(pll_ready_o), 16'd1);

    // 3b: same glitch late in the attempt -> timeout and retry
    step(1'b1, 1'b1);
    run_until("wait", 1'b0, 20);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0);
    for (int i = 0; i < 30 && m_hi < 6; i++) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    run_until("pulse", 1'b1, 40);
    #1;
    check("t3_retry", 16'(retry_cnt_o), 16'd1);

    // 4: lock loss in RUN
    run_until("run", 1'b1, 60);
    repeat (3) step(1'b0, 1'b0);
    #1;
    check("t4_loss", {sys_rst_n_o, pll_reset_o, 6'd0, lock_loss_cnt_o}, 16'h4001);
    run_until("run", 1'b1, 60);

    // 5b: lock drop coincident with relock request counts as a loss
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    #1;
    check("t5_coincident_loss", 16'(lock_loss_cnt_o), 16'd2);
    run_until("run", 1'b1, 60);

    // 4b: saturate the loss counter
    for (int n = 0; n < 300; n++) begin
      repeat (3) step(1'b0, 1'b0);
      run_until("run", 1'b1, 60);
    end
    check("t4_loss_sat", 16'(lock_loss_cnt_o), 16'd255);

    // 6: asynchronous reset mid-cycle during WAIT_LOCK
    run_until("wait", 1'b0, 20);
    repeat (5) step(1'b0, 1'b0);
    do_reset();
    count_pulse("t6_pulse_width", 12, PULSE);

    // random lock waveforms with sporadic relock requests
    cur = 1'b0;
    for (int blk = 0; blk < 3; blk++) begin
      do_reset();
      seg = 0;
      for (int i = 0; i < 800; i++) begin
        if (seg == 0) begin
          cur = ~cur;
          seg = cur ? int'($urandom_range(1, 60)) : int'($urandom_range(1, 40));
        end
        seg--;
        step(cur, $urandom_range(0, 39) == 0);
      end
    end

    #2;
    if (exp_q.size() != 0) begin
      total++; bad++;
      $display("FAIL queue_drain got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
